// File: rtl/pid_pkg.sv
// Shared types and constants for the PID actuator path.
package pid_pkg;
   localparam int unsigned CTRL_W = 16;
   localparam logic [CTRL_W-1:0] CTRL_MAX = 16'h7FFF;
   localparam logic [CTRL_W-1:0] CTRL_MIN = 16'h8000;

   typedef enum logic {RUN, DEAD} pwm_state_t;
endpackage

// File: rtl/pid_pwm_duty_scale.sv
// Combinational magnitude-to-duty scaling: |control_in| * PERIOD >> 15, -0x8000 saturated.
module pid_pwm_duty_scale
   import pid_pkg::*;
#(
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned PERIOD = 1000
) (
   input  logic [CTRL_W-1:0] control_in,
   output logic [CNT_W-1:0]  duty
);
   localparam int unsigned PROD_W = CTRL_W - 1 + CNT_W;
   localparam logic [PROD_W-1:0] PERIOD_X = PROD_W'(PERIOD);

   logic [CTRL_W-1:0] mag;

   always_comb begin
      if (control_in == CTRL_MIN)
         mag = CTRL_MAX;
      else if (control_in[CTRL_W-1])
         mag = -control_in;
      else
         mag = control_in;
   end

   // mag < 2**15 and PERIOD <= 2**CNT_W, so the product fits PROD_W and the result is < PERIOD
   assign duty = CNT_W'((PROD_W'(mag) * PERIOD_X) >> (CTRL_W - 1));
endmodule

// File: rtl/pid_pwm_actuator.sv
// PWM + direction actuator with double-buffered duty/dir applied at period boundaries.
// Optional direction-reversal blanking is built when PWM_DEADTIME_EN is defined.
module pid_pwm_actuator
   import pid_pkg::*;
#(
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned PERIOD   = 1000,
   parameter int unsigned DEADTIME = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [CTRL_W-1:0] control_in,
   input  logic              control_valid,
   output logic              pwm_out,
   output logic              dir_out,
   output logic              sync_out,
   output logic [CNT_W-1:0]  duty_out
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] duty_pend, duty_pend_nxt;
   logic [CNT_W-1:0] duty_active, duty_active_nxt;
   logic [CNT_W-1:0] duty_scaled, duty_new;
   logic             dir_pend, dir_pend_nxt, dir_nxt, dir_new;
   logic             run_q, boundary, pwm_nxt, sync_nxt;
   pwm_state_t       state, state_nxt;

`ifdef PWM_DEADTIME_EN
   localparam int unsigned DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);
   logic [DW-1:0] dead_cnt, dead_cnt_nxt;
`endif

   pid_pwm_duty_scale #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD)
   ) u_scale (
      .control_in (control_in),
      .duty       (duty_scaled)
   );

   // Outputs are registered from next-state values so pwm_out/sync_out line up with cnt.
   // The first enabled cycle after reset or disable parks cnt at 0 and opens a fresh period.
   always_comb begin
      cnt_nxt         = '0;
      duty_pend_nxt   = duty_pend;
      dir_pend_nxt    = dir_pend;
      duty_active_nxt = duty_active;
      dir_nxt         = dir_out;
      state_nxt       = state;
      boundary        = enable && run_q && (cnt == LAST);
      duty_new        = control_valid ? duty_scaled : duty_pend;
      dir_new         = control_valid ? control_in[CTRL_W-1] : dir_pend;
`ifdef PWM_DEADTIME_EN
      dead_cnt_nxt    = dead_cnt;
`endif

      if (control_valid) begin
         duty_pend_nxt = duty_scaled;
         dir_pend_nxt  = control_in[CTRL_W-1];
      end

      if (enable && run_q && (cnt != LAST))
         cnt_nxt = cnt + CNT_W'(1);

      if (boundary) begin
         duty_active_nxt = duty_new;
         dir_nxt         = dir_new;
      end

`ifdef PWM_DEADTIME_EN
      case (state)
         RUN: begin
            if (boundary && (dir_new != dir_out) && (DEADTIME > 0)) begin
               state_nxt    = DEAD;
               dead_cnt_nxt = '0;
            end
         end
         DEAD: begin
            if (!enable) begin
               state_nxt    = RUN;
               dead_cnt_nxt = '0;
            end else if (boundary && (dir_new != dir_out)) begin
               dead_cnt_nxt = '0;
            end else if (dead_cnt == DEAD_LAST) begin
               state_nxt    = RUN;
               dead_cnt_nxt = '0;
            end else begin
               dead_cnt_nxt = dead_cnt + DW'(1);
            end
         end
         default: state_nxt = RUN;
      endcase
`else
      state_nxt = RUN;
`endif

      pwm_nxt  = enable && (state_nxt == RUN) && (cnt_nxt < duty_active_nxt);
      sync_nxt = enable && (cnt_nxt == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         duty_pend   <= '0;
         duty_active <= '0;
         dir_pend    <= 1'b0;
         dir_out     <= 1'b0;
         pwm_out     <= 1'b0;
         sync_out    <= 1'b0;
         run_q       <= 1'b0;
         state       <= RUN;
`ifdef PWM_DEADTIME_EN
         dead_cnt    <= '0;
`endif
      end else begin
         cnt         <= cnt_nxt;
         duty_pend   <= duty_pend_nxt;
         duty_active <= duty_active_nxt;
         dir_pend    <= dir_pend_nxt;
         dir_out     <= dir_nxt;
         pwm_out     <= pwm_nxt;
         sync_out    <= sync_nxt;
         run_q       <= enable;
         state       <= state_nxt;
`ifdef PWM_DEADTIME_EN
         dead_cnt    <= dead_cnt_nxt;
`endif
      end
   end

   assign duty_out = duty_active;
endmodule

// File: tb/tb_pid_pwm_actuator.sv
// Self-checking bench for pid_pwm_actuator (PERIOD=1000, DEADTIME=8).
module tb_pid_pwm_actuator;
   localparam int PER = 1000;
`ifdef PWM_DEADTIME_EN
   localparam int DT = 8;
`else
   localparam int DT = 0;
`endif
   localparam int NV = 10;

   logic        clk = 1'b0;
   logic        reset, enable, control_valid;
   logic [15:0] control_in;
   logic        pwm_out, dir_out, sync_out;
   logic [9:0]  duty_out;

   pid_pwm_actuator #(
      .CNT_W    (10),
      .PERIOD   (PER),
      .DEADTIME (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .control_in    (control_in),
      .control_valid (control_valid),
      .pwm_out       (pwm_out),
      .dir_out       (dir_out),
      .sync_out      (sync_out),
      .duty_out      (duty_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ctrl;
      int          at_cnt;
      bit          early_en;
      logic [15:0] early_ctrl;
      int          exp_duty;
      int          exp_dir;
   } vec_t;

   typedef struct {
      int duty;
      int dir;
      int highs;
   } exp_t;

   vec_t vecs [NV];
   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endfunction

   function automatic int exp_highs(int duty, bit flip);
      if (flip && DT > 0)
         return (duty > DT) ? duty - DT : 0;
      return duty;
   endfunction

   task automatic wait_sync(input int max_cyc, output bit found, output int n);
      found = 1'b0;
      n = 0;
      while (n < max_cyc && !found) begin
         @(negedge clk);
         n++;
         if (sync_out) found = 1'b1;
      end
   endtask

   initial begin
      bit          found;
      int          n, highs, changes, z, prev_dir;
      logic [9:0]  d0;
      exp_t        e;

      vecs[0] = '{16'h4000, 200, 1'b0, 16'h0000, 500, 0};
      vecs[1] = '{16'hC000, 200, 1'b0, 16'h0000, 500, 1};
      vecs[2] = '{16'h8000, 500, 1'b0, 16'h0000, 999, 1};
      vecs[3] = '{16'h7FFF, 200, 1'b0, 16'h0000, 999, 0};
      vecs[4] = '{16'h0000, 200, 1'b0, 16'h0000,   0, 0};
      vecs[5] = '{16'h0021, 200, 1'b0, 16'h0000,   1, 0};
      vecs[6] = '{16'hFFFF, 200, 1'b0, 16'h0000,   0, 1};
      vecs[7] = '{16'h8001, 200, 1'b0, 16'h0000, 999, 1};
      vecs[8] = '{16'h2000, 999, 1'b1, 16'h1000, 250, 0};
      vecs[9] = '{16'h0000,   0, 1'b0, 16'h0000,   0, 0};

      reset = 1'b1;
      enable = 1'b1;
      control_in = '0;
      control_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pwm", pwm_out, 0);
      chk("reset_dir", dir_out, 0);
      chk("reset_sync", sync_out, 0);
      chk("reset_duty", duty_out, 0);

      reset = 1'b0;
      wait_sync(5, found, n);
      chk("first_sync_found", found, 1);

      // Each period: check what was queued for it, strobe the next vector, count pwm highs
      sb.push_back(exp_t'{0, 0, 0});
      prev_dir = 0;
      for (int i = 0; i <= NV; i++) begin
         if (sb.size() > 0) e = sb.pop_front();
         else e = exp_t'{-1, -1, -1};
         chk($sformatf("duty[%0d]", i), duty_out, e.duty);
         chk($sformatf("dir[%0d]", i), dir_out, e.dir);
         d0 = duty_out;
         highs = 0;
         changes = 0;
         for (int k = 0; k < PER; k++) begin
            highs += int'(pwm_out);
            if (k > 0 && (sync_out || duty_out != d0)) changes++;
            control_valid = 1'b0;
            if (i < NV) begin
               if (vecs[i].early_en && k == 300) begin
                  control_in = vecs[i].early_ctrl;
                  control_valid = 1'b1;
               end
               if (k == vecs[i].at_cnt) begin
                  control_in = vecs[i].ctrl;
                  control_valid = 1'b1;
                  sb.push_back(exp_t'{vecs[i].exp_duty, vecs[i].exp_dir,
                     exp_highs(vecs[i].exp_duty, vecs[i].exp_dir != prev_dir)});
                  prev_dir = vecs[i].exp_dir;
               end
            end
            @(negedge clk);
         end
         control_valid = 1'b0;
         chk($sformatf("highs[%0d]", i), highs, e.highs);
         chk($sformatf("mid_period_change[%0d]", i), changes, 0);
         chk($sformatf("sync_period_end[%0d]", i), sync_out, 1);
      end

      // Disable: outputs idle, pending still captured
      enable = 1'b0;
      z = 0;
      for (int k = 0; k < 30; k++) begin
         control_valid = (k == 10);
         if (k == 10) control_in = 16'h4000;
         @(negedge clk);
         z += int'(pwm_out) + int'(sync_out);
      end
      control_valid = 1'b0;
      chk("disabled_outputs", z, 0);
      chk("disabled_duty_hold", duty_out, 0);

      enable = 1'b1;
      wait_sync(5, found, n);
      chk("reenable_sync_latency", n, 1);
      wait_sync(1100, found, n);
      chk("reenable_period", n, PER);
      chk("pending_captured_while_disabled", duty_out, 500);
      repeat (300) @(negedge clk);
      chk("pre_reset_pwm", pwm_out, 1);

      // Asynchronous reset mid-pulse
      reset = 1'b1;
      #1;
      chk("async_reset_pwm", pwm_out, 0);
      chk("async_reset_duty", duty_out, 0);
      chk("async_reset_dir", dir_out, 0);
      chk("async_reset_sync", sync_out, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_sync(5, found, n);
      chk("post_reset_sync_latency", n, 1);
      highs = int'(pwm_out);
      for (int k = 1; k < PER; k++) begin
         @(negedge clk);
         highs += int'(pwm_out);
      end
      chk("post_reset_pwm_idle", highs, 0);
      @(negedge clk);
      chk("post_reset_period", sync_out, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
